fd_prog_delay_line: RTL
=======================

Name: fd_prog_delay_line

Overview:
- Synthesizable, multi-channel, clock-cycle-granular programmable delay line. It is the clocked successor to the single-channel tap-delay chip model.
- Each channel delays a g_width-bit sample stream by a per-channel programmed number of clocks.
- The delay value is loaded on a latch-enable rising edge.
- Used in the fine-delay core for coarse delay alignment and for test-bench-free loopback of trigger/pulse paths.

Parameters:
- g_num_channels, 4, number of independent delay channels.
- g_width, 1, sample width per channel in bits.
- g_depth, 1024, history depth per channel in samples; must be a power of 2, minimum 4.
- g_delay_bits, 10, width of the per-channel delay code; must satisfy 2^g_delay_bits >= g_depth.

Ports:
- clk_sys_i, in, 1, system clock; every register is clocked on its rising edge.
- rst_n_i, in, 1, asynchronous active-low reset.
- d_i, in, g_num_channels*g_width, input samples; channel c occupies bits [c*g_width +: g_width].
- len_i, in, g_num_channels, per-channel latch enable; a delay load happens on the rising edge only.
- delay_i, in, g_num_channels*g_delay_bits, per-channel delay code, sampled on the len_i rising edge.
- q_o, out, g_num_channels*g_width, delayed samples, registered.
- busy_o, out, g_num_channels, channel is ramping toward a new delay (see Optional Feature).
- range_err_o, out, g_num_channels, sticky flag: the last loaded code was clamped.
- primed_o, out, 1, history buffer fully written since reset.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - q_o=0, busy_o=0, range_err_o=0, primed_o=0.
  - Per-channel cur_dly=0 and target=0; len edge registers=0; wr_ptr=0; fill counter=0.
  - Buffer RAM contents are not reset.
- Write side, every cycle:
  - mem[c][wr_ptr] <= d_i[c].
  - wr_ptr increments modulo g_depth and wraps g_depth-1 -> 0.
  - The fill counter increments and saturates at g_depth-1.
- Read side:
  - rd_ptr = (wr_ptr - 1 - cur_dly) mod g_depth; unsigned arithmetic on log2(g_depth) bits, wrap implicit.
  - q_o registered from mem[rd_ptr].
  - Latency: a sample presented on d_i at edge k appears on q_o at edge k+cur_dly+1. cur_dly=0 therefore gives 1 clock.
- Unwritten-history masking: if cur_dly >= fill count, q_o outputs 0 for that channel. Stale RAM must never leak after reset.
- primed_o:
  - Rises one cycle after the fill counter saturates.
  - Stays high until the next reset.
- Delay load:
  - A load occurs at edge N when len_i[c]=1 at edge N and len_i[c] was 0 at edge N-1.
  - delay_i is captured at edge N into target[c].
  - Without ramp, cur_dly[c] is also set at edge N.
  - q_o sampled at edge N+1 uses the new delay.
  - A held-high len_i does not reload.
- Range: the legal delay is 0..g_depth-2.
  - A code >= g_depth-1 clamps to g_depth-2 and sets range_err_o[c].
  - The next in-range load clears range_err_o[c].
  - Clamp and flag are updated in the same cycle as the load.
- Channels are fully independent. Simultaneous loads on several channels are all honoured in the same cycle.
- Reset mid-operation, including mid-ramp: all state returns to reset values immediately; no load completes.

Optional Feature:
- Macro: FD_DLY_RAMP_EN.
- Defined:
  - A load sets only target[c].
  - cur_dly[c] steps by exactly 1 per clock toward target[c], so at most one sample is dropped or duplicated per cycle.
  - busy_o[c]=1 whenever cur_dly[c] != target[c] and falls in the cycle cur_dly reaches target.
  - A new load during a ramp retargets; the ramp continues from the current cur_dly with no jump.
  - A load equal to cur_dly leaves busy_o low.
- Undefined:
  - cur_dly jumps in the load cycle.
  - busy_o is tied to 0.

Test Plan:
- Single-cycle pulse on ch0 after load delay=5 -> pulse on q_o[0] exactly 6 clocks after input; other channels unaffected.
- Loads of 0, g_depth-2=1022, and 1023 -> latencies of 1 and 1023 clocks for the first two; the 1023 load clamps to 1022 with range_err_o[0]=1, which clears after a subsequent load of 10.
- Immediately after reset, load delay=100 and drive d_i=1 constantly -> q_o=0 for the first 100 cycles, then 1; primed_o rises at cycle 1024.
- Assert rst_n_i low asynchronously between clock edges during operation -> all outputs 0 before the next edge; after release, latency equals the reset-default 1 clock.
- Hold len_i high for 20 cycles while delay_i changes -> only the value at the rising edge is loaded.
- FD_DLY_RAMP_EN: load 3 then 8 -> busy_o high for exactly 5 cycles, cur_dly visits 4..8; a retarget to 2 mid-ramp at cur_dly=6 -> busy_o stays high and cur_dly descends 5,4,3,2.

Source files
------------

// File: rtl/fd_prog_delay_line.sv
// fd_prog_delay_line: multi-channel, clock-granular programmable delay line.
// Each channel writes its input sample into a private circular history buffer
// every clock and reads it back cur_dly+1 clocks later. A code is loaded on
// the rising edge of that channel's len_i and is clamped to g_depth-2.
// Optional feature macro: FD_DLY_RAMP_EN. When it is defined, a load retargets
// the channel and cur_dly walks toward the target one step per clock, with
// busy_o high meanwhile. When it is undefined, cur_dly jumps in the load cycle
// and busy_o is tied low.
`timescale 1ns/1ps
module fd_prog_delay_line #(
  parameter int g_num_channels = 4,
  parameter int g_width        = 1,
  parameter int g_depth        = 1024,
  parameter int g_delay_bits   = 10
) (
  input  logic                                   clk_sys_i,
  input  logic                                   rst_n_i,
  input  logic [g_num_channels*g_width-1:0]      d_i,
  input  logic [g_num_channels-1:0]              len_i,
  input  logic [g_num_channels*g_delay_bits-1:0] delay_i,
  output logic [g_num_channels*g_width-1:0]      q_o,
  output logic [g_num_channels-1:0]              busy_o,
  output logic [g_num_channels-1:0]              range_err_o,
  output logic                                   primed_o
);

  localparam int c_aw = $clog2(g_depth);
  typedef logic [c_aw-1:0] addr_t;

  localparam addr_t c_last    = addr_t'(g_depth - 1);
  localparam addr_t c_dly_max = addr_t'(g_depth - 2);
  // Codes at or above this value are out of range.
  localparam logic [g_delay_bits-1:0] c_code_lim = g_delay_bits'(g_depth - 1);

  addr_t                     r_wr_ptr;
  addr_t                     r_fill;
  logic                      r_primed;
  logic [g_num_channels-1:0] r_len_q;
  logic [g_num_channels-1:0] w_load;

  // A load happens only on a 0->1 transition of len_i.
  assign w_load = len_i & ~r_len_q;

  // Shared write pointer, fill counter, priming flag and len_i history.
  // NOTE: sequential state is assigned non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_primed <= 1'b0;
      r_len_q  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + addr_t'(1);
      if (r_fill != c_last) begin
        r_fill <= r_fill + addr_t'(1);
      end else begin
        r_primed <= 1'b1;
      end
      r_len_q <= len_i;
    end
  end

  assign primed_o = r_primed;

  for (genvar c = 0; c < g_num_channels; c++) begin : g_ch
    logic [g_delay_bits-1:0] w_code;
    logic                    w_clamp;
    addr_t                   w_code_sat;
    addr_t                   w_rd_ptr;
    logic                    w_unwritten;
    addr_t                   r_cur;
    logic                    r_err;
    logic [g_width-1:0]      r_q;
    logic [g_width-1:0]      r_mem [g_depth];

    assign w_code      = delay_i[c*g_delay_bits +: g_delay_bits];
    assign w_clamp     = (w_code >= c_code_lim);
    assign w_code_sat  = w_clamp ? c_dly_max : addr_t'(w_code);
    // cur_dly <= g_depth-2, so the read address never collides with the write address.
    assign w_rd_ptr    = r_wr_ptr - addr_t'(1) - r_cur;
    // The slot being read has not been written since reset.
    assign w_unwritten = (r_cur >= r_fill);

`ifdef FD_DLY_RAMP_EN
    addr_t r_tgt;

    // Load retargets only; cur_dly holds in the load cycle, then steps by one per clock.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_tgt <= '0;
        r_cur <= '0;
      end else if (w_load[c]) begin
        r_tgt <= w_code_sat;
      end else if (r_cur < r_tgt) begin
        r_cur <= r_cur + addr_t'(1);
      end else if (r_cur > r_tgt) begin
        r_cur <= r_cur - addr_t'(1);
      end
    end

    assign busy_o[c] = (r_cur != r_tgt);
`else
    // Without ramping the current delay is the target and jumps in the load cycle.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_cur <= '0;
      end else if (w_load[c]) begin
        r_cur <= w_code_sat;
      end
    end

    assign busy_o[c] = 1'b0;
`endif

    // Sticky clamp flag, rewritten by every load.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_err <= 1'b0;
      end else if (w_load[c]) begin
        r_err <= w_clamp;
      end
    end

    // History write, one slot per clock.
    // NOTE: the RAM has no reset (keeps it mappable to block RAM); stale data is masked on read.
    always_ff @(posedge clk_sys_i) begin
      r_mem[r_wr_ptr] <= d_i[c*g_width +: g_width];
    end

    // Registered read-out; slots not yet written since reset read as zero.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_q <= '0;
      end else begin
        r_q <= w_unwritten ? '0 : r_mem[w_rd_ptr];
      end
    end

    assign q_o[c*g_width +: g_width] = r_q;
    assign range_err_o[c]            = r_err;
  end

endmodule
